// File: rtl/int_add_feeder_pkg.sv
// ---------------------------------------------------------------------------
// int_add_feeder_pkg
// Shared constants and types for the integer-adder operand feeder.
//   DEF_OP_BITWIDTH : default operand/result width
//   DEF_FIFO_DEPTH  : default number of buffered operand pairs
//   ERR_CNT_W       : width of the approximate-result mismatch counter
//   add_rec_t       : {a, b, d} result record at the default width
//   err_sat_inc     : saturating increment for the mismatch counter
// ---------------------------------------------------------------------------
package int_add_feeder_pkg;

    localparam int DEF_OP_BITWIDTH = 32;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int ERR_CNT_W       = 16;

    typedef struct packed {
        logic [DEF_OP_BITWIDTH-1:0] a;
        logic [DEF_OP_BITWIDTH-1:0] b;
        logic [DEF_OP_BITWIDTH-1:0] d;
    } add_rec_t;

    // Sticks at all-ones instead of wrapping back to zero.
    function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/int_add_pair_fifo.sv
// ---------------------------------------------------------------------------
// int_add_pair_fifo
// Synchronous FIFO holding packed {a, b} operand pairs.
// Ports:
//   clk, racc       : clock, asynchronous active-high reset (empties FIFO)
//   push, push_data : write strobe and data (ignored while full)
//   pop             : read strobe (ignored while empty)
//   head            : data at the read pointer (valid while !empty)
//   full, empty     : occupancy flags
// Pointers carry one extra wrap bit so that full and empty are
// distinguishable when the index bits are equal.
// ---------------------------------------------------------------------------
module int_add_pair_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              racc,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge racc) begin
        if (racc) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, so clearing the data would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/int_add_operand_feeder.sv
// ---------------------------------------------------------------------------
// int_add_operand_feeder
// Buffers operand pairs, presents them to an external combinational adder
// and registers the aligned {a, b, d} record for downstream consumption.
// Pipeline: pair FIFO -> issue register (drives add_a/add_b) -> output reg.
// Ports:
//   clk, racc                  : clock, asynchronous active-high reset
//   in_valid/in_ready/in_a/in_b: upstream operand-pair handshake
//   add_a, add_b               : operands to the external adder
//   add_d                      : adder result, combinational in add_a/add_b
//   out_valid/out_ready/out_a/out_b/out_d : result record handshake
//   err_cnt                    : approximate-result mismatch count
// Optional build macro ERR_MONITOR_EN: compares add_d against an exact sum
// on every output load and counts mismatches (saturating). Without it,
// err_cnt is tied to zero and no exact adder exists.
// ---------------------------------------------------------------------------
module int_add_operand_feeder
    import int_add_feeder_pkg::*;
#(
    parameter int OP_BITWIDTH = DEF_OP_BITWIDTH,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   racc,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_BITWIDTH-1:0] in_a,
    input  logic [OP_BITWIDTH-1:0] in_b,
    output logic [OP_BITWIDTH-1:0] add_a,
    output logic [OP_BITWIDTH-1:0] add_b,
    input  logic [OP_BITWIDTH-1:0] add_d,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OP_BITWIDTH-1:0] out_a,
    output logic [OP_BITWIDTH-1:0] out_b,
    output logic [OP_BITWIDTH-1:0] out_d,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    logic                     rdy_en;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [2*OP_BITWIDTH-1:0] fifo_head;
    logic                     push;
    logic                     pop;
    logic                     adv_out;
    logic                     iss_v;
    logic [OP_BITWIDTH-1:0]   iss_a;
    logic [OP_BITWIDTH-1:0]   iss_b;

    // rdy_en keeps in_ready low during reset and raises it on the first
    // edge after reset is released.
    always_ff @(posedge clk or posedge racc) begin
        if (racc) rdy_en <= 1'b0;
        else      rdy_en <= 1'b1;
    end

    assign in_ready = rdy_en && !fifo_full;
    assign push     = in_valid && in_ready;

    // The output register advances when it is empty or being drained; the
    // issue register refills whenever it is empty or moving forward.
    assign adv_out  = iss_v && (!out_valid || out_ready);
    assign pop      = !fifo_empty && (!iss_v || adv_out);

    int_add_pair_fifo #(
        .DATA_W (2*OP_BITWIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .racc      (racc),
        .push      (push),
        .push_data ({in_a, in_b}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Issue register: iss_a/iss_b change only on a pop, so the adder
    // operands hold their last values while iss_v is low.
    always_ff @(posedge clk or posedge racc) begin
        if (racc) begin
            iss_v <= 1'b0;
            iss_a <= '0;
            iss_b <= '0;
        end else if (pop) begin
            iss_v          <= 1'b1;
            {iss_a, iss_b} <= fifo_head;
        end else if (adv_out) begin
            iss_v <= 1'b0;
        end
    end

    assign add_a = iss_a;
    assign add_b = iss_b;

    // Output register: captures the operands together with the adder result
    // so the record stays aligned; holds while stalled.
    always_ff @(posedge clk or posedge racc) begin
        if (racc) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_d     <= '0;
        end else if (adv_out) begin
            out_valid <= 1'b1;
            out_a     <= iss_a;
            out_b     <= iss_b;
            out_d     <= add_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ERR_MONITOR_EN
    logic [OP_BITWIDTH-1:0] exact_sum;
    logic [ERR_CNT_W-1:0]   err_cnt_q;

    assign exact_sum = iss_a + iss_b;

    always_ff @(posedge clk or posedge racc) begin
        if (racc) begin
            err_cnt_q <= '0;
        end else if (adv_out && (add_d != exact_sum)) begin
            err_cnt_q <= err_sat_inc(err_cnt_q);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_int_add_operand_feeder.sv
// ---------------------------------------------------------------------------
// tb_int_add_operand_feeder
// Self-checking bench for int_add_operand_feeder. The bench supplies the
// combinational adder (exact, or exact-minus-one when adder_faulty is set)
// and checks the output stream against a reference built from the list of
// accepted pairs: output i must be {a_i, b_i, a_i + b_i (- 1)} mod 2^32.
// ---------------------------------------------------------------------------
module tb_int_add_operand_feeder;
    import int_add_feeder_pkg::*;

    localparam int W = DEF_OP_BITWIDTH;

    logic           clk;
    logic           racc;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_d;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_a;
    logic [W-1:0]   out_b;
    logic [W-1:0]   out_d;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic           adder_faulty;

    int vectors;
    int miscompares;
    int cyc;

    add_rec_t sent_q[$];
    add_rec_t got_q[$];
    int       got_cyc_q[$];
    logic     smp_in_ready;
    logic     smp_out_valid;
    add_rec_t smp_out;

    int_add_operand_feeder dut (
        .clk       (clk),
        .racc      (racc),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_d     (add_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_d     (out_d),
        .err_cnt   (err_cnt)
    );

    assign add_d = add_a + add_b - W'(adder_faulty);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the record the block must emit for an accepted pair.
    function automatic add_rec_t model(input add_rec_t s, input logic faulty);
        add_rec_t r;
        r   = s;
        r.d = s.a + s.b;
        if (faulty) r.d = r.d - 1;
        return r;
    endfunction

    // One clock: sample handshakes at the falling edge, then return just
    // after the next rising edge where new stimulus is driven.
    task automatic tick();
        add_rec_t r;
        @(negedge clk);
        cyc++;
        smp_in_ready  = in_ready;
        smp_out_valid = out_valid;
        smp_out       = '{a: out_a, b: out_b, d: out_d};
        if (in_valid && in_ready) begin
            r = '{a: in_a, b: in_b, d: '0};
            sent_q.push_back(r);
        end
        if (out_valid && out_ready) begin
            got_q.push_back(smp_out);
            got_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        sent_q.delete();
        got_q.delete();
        got_cyc_q.delete();
    endtask

    task automatic test_reset();
        racc = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b0; adder_faulty = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({in_ready, out_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_flags: in_ready/out_valid=%b required 00", {in_ready, out_valid});
        end
        vectors++;
        if ({out_a, out_b, out_d, add_a, add_b} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: out_a=%h out_b=%h out_d=%h add_a=%h add_b=%h required 0",
                     out_a, out_b, out_d, add_a, add_b);
        end
        vectors++;
        if (err_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_err_cnt: got %0d required 0", err_cnt);
        end
        racc = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_before_edge: got %b required 0", in_ready);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_edge: got %b required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_a = 5; in_b = 7; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL single_early_valid[%0d]: got %b required 0", k, out_valid);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        vectors++;
        if ({out_valid, out_a, out_b, out_d} !== {1'b1, W'(5), W'(7), W'(12)}) begin
            miscompares++;
            $display("FAIL single_out: valid=%b a=%0d b=%0d d=%0d required 1 5 7 12",
                     out_valid, out_a, out_b, out_d);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if ({out_valid, add_a, add_b} !== {1'b0, W'(5), W'(7)}) begin
            miscompares++;
            $display("FAIL single_hold: valid=%b add_a=%0d add_b=%0d required 0 5 7",
                     out_valid, add_a, add_b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int guard;
        clear_queues();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
            tick();
            vectors++;
            if (smp_in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_in_ready[%0d]: got %b required 1", i, smp_in_ready);
            end
        end
        in_valid = 1'b0;
        guard = 0;
        while (got_q.size() < 12 && guard < 20) begin
            tick();
            guard++;
        end
        vectors++;
        if (got_q.size() !== 12) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d outputs required 12", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < sent_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== model(sent_q[i], adder_faulty) || got_cyc_q[i] !== got_cyc_q[0] + i) begin
                miscompares++;
                $display("FAIL b2b_out[%0d]: got %h at cycle %0d required %h at cycle %0d",
                         i, got_q[i], got_cyc_q[i], model(sent_q[i], adder_faulty), got_cyc_q[0] + i);
            end
        end
    endtask

    task automatic test_stall();
        int       guard;
        add_rec_t held;
        clear_queues();
        out_ready = 1'b0;
        guard = 0;
        while (sent_q.size() < 6 && guard < 20) begin
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
            tick();
            guard++;
        end
        vectors++;
        if (guard !== 6) begin
            miscompares++;
            $display("FAIL stall_fill_cycles: took %0d cycles required 6", guard);
        end
        in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 0) held = smp_out;
            vectors++;
            if (smp_in_ready !== 1'b0 || smp_out_valid !== 1'b1 || smp_out !== held
                || held !== model(sent_q[0], adder_faulty)) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: in_ready=%b out_valid=%b out=%h required 0 1 %h",
                         k, smp_in_ready, smp_out_valid, smp_out, model(sent_q[0], adder_faulty));
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (got_q.size() < 6 && guard < 30) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        vectors++;
        if (got_q.size() !== 6 || sent_q.size() !== 6) begin
            miscompares++;
            $display("FAIL stall_count: got %0d outputs from %0d pushes required 6/6",
                     got_q.size(), sent_q.size());
        end
        for (int i = 0; i < got_q.size() && i < sent_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== model(sent_q[i], adder_faulty)) begin
                miscompares++;
                $display("FAIL stall_out[%0d]: got %h required %h", i, got_q[i], model(sent_q[i], adder_faulty));
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        clear_queues();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
            tick();
        end
        in_valid = 1'b0;
        #2 racc = 1'b1;
        #1;
        vectors++;
        if ({out_valid, in_ready, out_a, out_b, out_d, add_a, add_b} !== '0) begin
            miscompares++;
            $display("FAIL midreset_clear: valid=%b ready=%b a=%h b=%h d=%h add_a=%h add_b=%h required 0",
                     out_valid, in_ready, out_a, out_b, out_d, add_a, add_b);
        end
        @(posedge clk);
        #1;
        racc = 1'b0;
        tick();
        clear_queues();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = '1; in_b = 1;
        guard = 0;
        while (sent_q.size() < 1 && guard < 5) begin
            tick();
            guard++;
        end
        in_valid = 1'b0;
        repeat (8) tick();
        vectors++;
        if (got_q.size() !== 1) begin
            miscompares++;
            $display("FAIL midreset_count: got %0d outputs required 1", got_q.size());
        end
        if (got_q.size() > 0) begin
            vectors++;
            if (got_q[0] !== '{a: '1, b: W'(1), d: '0}) begin
                miscompares++;
                $display("FAIL midreset_wrap: got %h required a=ffffffff b=1 d=0", got_q[0]);
            end
        end
    endtask

    task automatic test_err_monitor();
        int guard;
        logic [ERR_CNT_W-1:0] exp_cnt;
        clear_queues();
`ifdef ERR_MONITOR_EN
        exp_cnt = 10;
`else
        exp_cnt = 0;
`endif
        adder_faulty = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
            tick();
        end
        in_valid = 1'b0;
        guard = 0;
        while (got_q.size() < 10 && guard < 20) begin
            tick();
            guard++;
        end
        vectors++;
        if (got_q.size() !== 10) begin
            miscompares++;
            $display("FAIL err_count_outputs: got %0d required 10", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < sent_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== model(sent_q[i], 1'b1)) begin
                miscompares++;
                $display("FAIL err_out[%0d]: got %h required %h", i, got_q[i], model(sent_q[i], 1'b1));
            end
        end
        vectors++;
        if (err_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL err_cnt: got %0d required %0d", err_cnt, exp_cnt);
        end
        adder_faulty = 1'b0;
    endtask

    task automatic test_random();
        int guard;
        clear_queues();
        guard = 0;
        while (got_q.size() < 500 && guard < 20000) begin
            in_valid  = (sent_q.size() < 500) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_a      = $urandom;
            in_b      = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        vectors++;
        if (got_q.size() !== 500 || sent_q.size() !== 500) begin
            miscompares++;
            $display("FAIL rand_count: got %0d outputs from %0d pushes required 500/500",
                     got_q.size(), sent_q.size());
        end
        for (int i = 0; i < got_q.size() && i < sent_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== model(sent_q[i], adder_faulty)) begin
                miscompares++;
                $display("FAIL rand_out[%0d]: got %h required %h", i, got_q[i], model(sent_q[i], adder_faulty));
            end
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        cyc          = 0;
        adder_faulty = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_err_monitor();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
